// File: rtl/mul_pkg.sv
// Shared definitions for the multiply controller: op codes, FSM encoding
// and op classification helpers.
package mul_pkg;

  localparam int MUL_OP_W = 3;

  typedef enum logic [MUL_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MUL   = 3'd2,
    OP_MADD  = 3'd3,
    OP_MADDU = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MSUBU = 3'd6,
    OP_RSVD  = 3'd7
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL1 = 2'd1,
    ST_MUL2 = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  function automatic logic op_is_signed(input logic [MUL_OP_W-1:0] op);
    case (op)
      OP_MULT, OP_MUL, OP_MADD, OP_MSUB: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // MUL only returns its low word and RSVD does nothing architecturally.
  function automatic logic op_writes_hilo(input logic [MUL_OP_W-1:0] op);
    case (op)
      OP_MUL, OP_RSVD: return 1'b0;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/result handshake between the execute stage (master) and mul_ctrl (slave).
// A transfer happens on a cycle where valid && ready; valid must not depend on ready.
interface mul_ctrl_if #(parameter int OP_W = 3);
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/mul.sv
// Two-stage 32x32 multiplier, signed or unsigned; product appears two cycles
// after x/y are presented. No enable: both stages load every cycle.
module mul (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        mul_signed,
  output logic [63:0] result
);

  logic [32:0] xs_q;
  logic [32:0] ys_q;
  logic [63:0] prod_q;
  logic [63:0] xe;
  logic [63:0] ye;

  // A 64-bit product of sign-extended operands is exact modulo 2^64.
  assign xe = {{31{xs_q[32]}}, xs_q};
  assign ye = {{31{ys_q[32]}}, ys_q};

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      xs_q   <= '0;
      ys_q   <= '0;
      prod_q <= '0;
    end else begin
      xs_q   <= {mul_signed & x[31], x};
      ys_q   <= {mul_signed & y[31], y};
      prod_q <= xe * ye;
    end
  end

  assign result = prod_q;

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer around mul: one op in flight, HI/LO accumulate in MUL2, result held
// in DONE until taken, then HI/LO commit.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int OP_W = MUL_OP_W
) (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        flush,
  mul_ctrl_if.slave   bus,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output mul_state_e  dbg_state
);

  mul_state_e      state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [63:0]     result_q;
  logic [31:0]     hi_q, lo_q;
  logic [63:0]     mul_result;
  logic [31:0]     hi_fwd, lo_fwd;
  logic [63:0]     acc;
  logic            accept, capture, commit;

  mul u_mul (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .x          (bus.req_a),
    .y          (bus.req_b),
    .mul_signed (op_is_signed(bus.req_op)),
    .result     (mul_result)
  );

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    commit        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && !flush) begin
          accept  = 1'b1;
          state_d = ST_MUL1;
        end
      end
      ST_MUL1: state_d = ST_MUL2;
      ST_MUL2: begin
        capture = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush && state_q != ST_IDLE) begin
      capture = 1'b0;
      commit  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // Direct writes in the same cycle are forwarded so the accumulate sees them.
  assign hi_fwd = hi_we ? hilo_wdata : hi_q;
  assign lo_fwd = lo_we ? hilo_wdata : lo_q;

  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: acc = mul_result + {hi_fwd, lo_fwd};
      OP_MSUB, OP_MSUBU: acc = {hi_fwd, lo_fwd} - mul_result;
      OP_RSVD:           acc = '0;
      default:           acc = mul_result;
    endcase
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept)  op_q     <= bus.req_op;
      if (capture) result_q <= acc;
      if (commit && op_writes_hilo(op_q)) begin
        hi_q <= result_q[63:32];
        lo_q <= result_q[31:0];
      end else begin
        if (hi_we) hi_q <= hilo_wdata;
        if (lo_we) lo_q <= hilo_wdata;
      end
    end
  end

  // For MUL the low product word and the new LO coincide.
  assign bus.res_data = result_q[31:0];
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: directed cases plus randomized ops compared every cycle
// against an architectural HI/LO model and an expected-result queue.
module tb_mul_ctrl;
  import mul_pkg::*;

  logic        mul_clk;
  logic        resetn;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] hilo_wdata;
  logic [31:0] hi_out, lo_out;
  mul_state_e  dbg_state;

  mul_ctrl_if #(.OP_W(3)) bus ();

  mul_ctrl #(.OP_W(3)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .bus        (bus),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hilo_wdata (hilo_wdata),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  // model state
  logic [31:0] m_hi, m_lo;
  logic        exp_ready, exp_rv;
  logic [31:0] exp_q[$];
  bit          chk_en;
  int          n_cmp, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / compare process
  always @(negedge mul_clk) begin
    if (chk_en) begin
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("res_valid", 64'(bus.res_valid), 64'(exp_rv));
      if (exp_rv) begin
        if (exp_q.size() == 0) check("exp_q_empty", 64'd1, 64'd0);
        else                   check("res_data", 64'(bus.res_data), 64'(exp_q[0]));
      end
      check("hi_out", 64'(hi_out), 64'(m_hi));
      check("lo_out", 64'(lo_out), 64'(m_lo));
    end
  end

  function automatic logic [63:0] model_prod(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ae, be;
    if (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd5) begin
      ae = {{32{a[31]}}, a};
      be = {{32{b[31]}}, b};
    end else begin
      ae = {32'd0, a};
      be = {32'd0, b};
    end
    return ae * be;
  endfunction

  // driver tasks
  task automatic tick_we(input bit commit, input logic [63:0] val);
    @(posedge mul_clk);
    if (commit) {m_hi, m_lo} = val;
    else begin
      if (hi_we) m_hi = hilo_wdata;
      if (lo_we) m_lo = hilo_wdata;
    end
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic rand_we();
    hi_we      = 1'($urandom_range(0, 1));
    lo_we      = 1'($urandom_range(0, 1));
    hilo_wdata = $urandom;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    hi_we = 1'b1; hilo_wdata = h;
    tick_we(1'b0, 64'd0);
    lo_we = 1'b1; hilo_wdata = l;
    tick_we(1'b0, 64'd0);
  endtask

  // flush_at: 0 none, 1 in MUL1, 2 in MUL2, 3 in DONE alongside res_ready
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int flush_at, input bit rnd_we);
    logic [63:0] prod, hl, acc;
    bit          wr;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    tick_we(1'b0, 64'd0);
    bus.req_valid = 1'b0; bus.req_a = $urandom; bus.req_b = $urandom;
    exp_ready = 1'b0;
    if (rnd_we) rand_we();
    if (flush_at == 1) begin
      flush = 1'b1; tick_we(1'b0, 64'd0); flush = 1'b0; exp_ready = 1'b1;
      return;
    end
    tick_we(1'b0, 64'd0);
    if (rnd_we) rand_we();
    if (flush_at == 2) begin
      flush = 1'b1; tick_we(1'b0, 64'd0); flush = 1'b0; exp_ready = 1'b1;
      return;
    end
    hl   = {hi_we ? hilo_wdata : m_hi, lo_we ? hilo_wdata : m_lo};
    prod = model_prod(op, a, b);
    case (op)
      3'd3, 3'd4: acc = prod + hl;
      3'd5, 3'd6: acc = hl - prod;
      3'd7:       acc = 64'd0;
      default:    acc = prod;
    endcase
    tick_we(1'b0, 64'd0);
    exp_rv = 1'b1;
    exp_q.push_back(acc[31:0]);
    for (int i = 0; i < hold; i++) begin
      if (rnd_we) rand_we();
      tick_we(1'b0, 64'd0);
    end
    if (rnd_we) rand_we();
    bus.res_ready = 1'b1;
    if (flush_at == 3) flush = 1'b1;
    wr = (flush_at != 3) && (op != 3'd2) && (op != 3'd7);
    tick_we(wr, acc);
    bus.res_ready = 1'b0; flush = 1'b0;
    exp_rv = 1'b0; exp_ready = 1'b1;
    void'(exp_q.pop_front());
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    resetn = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.res_ready = 1'b0;
    m_hi = '0; m_lo = '0; exp_ready = 1'b1; exp_rv = 1'b0;
    repeat (3) @(posedge mul_clk);
    #1 resetn = 1'b1;
    @(negedge mul_clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk_en = 1'b1;
    @(posedge mul_clk); #1;

    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 0, 0, 1'b0);
    check("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo_out), 64'hFFFFFFFE);
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 0, 0, 1'b0);
    check("multu_hi", 64'(hi_out), 64'h00000001);
    check("multu_lo", 64'(lo_out), 64'hFFFFFFFE);
    write_hilo(32'h0, 32'h5);
    run_op(3'd3, 32'd3, 32'd4, 0, 0, 1'b0);
    check("madd_hi", 64'(hi_out), 64'h0);
    check("madd_lo", 64'(lo_out), 64'h11);
    write_hilo(32'h0, 32'h0);
    run_op(3'd6, 32'd1, 32'd1, 0, 0, 1'b0);
    check("msubu_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("msubu_lo", 64'(lo_out), 64'hFFFFFFFF);
    write_hilo(32'hAAAA0000, 32'h12345678);
    run_op(3'd2, 32'h00010000, 32'h00010000, 5, 0, 1'b0);
    check("mul_hi_kept", 64'(hi_out), 64'hAAAA0000);
    check("mul_lo_kept", 64'(lo_out), 64'h12345678);
    run_op(3'd3, 32'd7, 32'd9, 0, 2, 1'b0);
    check("flush_mul2_hi", 64'(hi_out), 64'hAAAA0000);
    check("flush_mul2_lo", 64'(lo_out), 64'h12345678);
    run_op(3'd4, 32'd7, 32'd9, 2, 3, 1'b0);
    check("flush_done_lo", 64'(lo_out), 64'h12345678);
    run_op(3'd7, 32'd5, 32'd6, 1, 0, 1'b0);
    check("rsvd_lo", 64'(lo_out), 64'h12345678);

    // flush in IDLE must block acceptance
    bus.req_valid = 1'b1; flush = 1'b1;
    tick_we(1'b0, 64'd0);
    bus.req_valid = 1'b0; flush = 1'b0;
    @(posedge mul_clk); #1;

    for (int n = 0; n < 60; n++) begin
      int fa;
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, int'($urandom_range(0, 3)), fa,
             1'b1);
      if ($urandom_range(0, 2) == 0) begin
        rand_we();
        tick_we(1'b0, 64'd0);
      end
    end

    // reset pulsed mid-op (during MUL1)
    write_hilo(32'h13579BDF, 32'h2468ACE0);
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 32'd11; bus.req_b = 32'd13;
    tick_we(1'b0, 64'd0);
    bus.req_valid = 1'b0; exp_ready = 1'b0;
    resetn = 1'b0;
    m_hi = '0; m_lo = '0; exp_ready = 1'b1; exp_rv = 1'b0; exp_q.delete();
    @(negedge mul_clk);
    check("rst_mid_res_data", 64'(bus.res_data), 64'd0);
    check("rst_mid_hi", 64'(hi_out), 64'd0);
    check("rst_mid_lo", 64'(lo_out), 64'd0);
    @(posedge mul_clk); #1 resetn = 1'b1;
    repeat (4) @(posedge mul_clk);
    @(negedge mul_clk);
    check("post_rst_valid", 64'(bus.res_valid), 64'd0);
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
